// File: rtl/mem_arb.sv
// Single-port memory arbiter between instruction fetch and data ports.
// Data has priority unless MAXD consecutive data grants have starved a pending fetch.
module mem_arb #(
   parameter int unsigned LAT  = 2,
   parameter int unsigned MAXD = 4
) (
   input  logic        clka,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        stallF,
   output logic        stallM
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

   localparam logic [2:0] LAT3  = 3'(LAT);
   localparam logic [2:0] MAXD3 = 3'(MAXD);

   state_e      state_q, state_d;
   logic [2:0]  lat_q, lat_d;
   logic [2:0]  dcnt_q, dcnt_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        if_ack_q, if_ack_d;
   logic        d_ack_q, d_ack_d;
   logic        grant_d, grant_i;

   always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      dcnt_d     = dcnt_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      if_ack_d   = 1'b0;
      d_ack_d    = 1'b0;
      grant_d    = 1'b0;
      grant_i    = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;

      case (state_q)
         IDLE: begin
            grant_d = d_req && !(if_req && (dcnt_q == MAXD3));
            grant_i = if_req && !grant_d;
            if (!if_req)
               dcnt_d = '0;
            if (grant_d) begin
               mem_en    = 1'b1;
               mem_we    = d_we;
               mem_addr  = d_addr;
               mem_wdata = d_wdata;
               if (if_req && (dcnt_q != MAXD3))
                  dcnt_d = dcnt_q + 3'd1;
               // Writes complete in one cycle: ack next cycle without leaving IDLE.
               if (d_we) begin
                  d_ack_d = 1'b1;
               end else begin
                  state_d = BUSY_D;
                  lat_d   = LAT3;
               end
            end else if (grant_i) begin
               mem_en   = 1'b1;
               mem_addr = if_addr;
               dcnt_d   = '0;
               state_d  = BUSY_I;
               lat_d    = LAT3;
            end
         end
         BUSY_I, BUSY_D: begin
            if (lat_q != 3'd0)
               lat_d = lat_q - 3'd1;
            // Last busy cycle: read data is valid now, ack lands as the counter hits zero.
            if (lat_q <= 3'd1) begin
               state_d = IDLE;
               if (state_q == BUSY_I) begin
                  if_rdata_d = mem_rdata;
                  if_ack_d   = 1'b1;
               end else begin
                  d_rdata_d = mem_rdata;
                  d_ack_d   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         mem_en    = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
      end
   end

   always_ff @(posedge clka) begin
      if (rst) begin
         state_q    <= IDLE;
         lat_q      <= '0;
         dcnt_q     <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         lat_q      <= lat_d;
         dcnt_q     <= dcnt_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         if_ack_q   <= if_ack_d;
         d_ack_q    <= d_ack_d;
      end
   end

   assign if_rdata = if_rdata_q;
   assign d_rdata  = d_rdata_q;
   assign if_ack   = if_ack_q;
   assign d_ack    = d_ack_q;
   assign stallF   = if_req & ~if_ack_q;
   assign stallM   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: LAT=2/MAXD=4 instance plus a LAT=1 instance for back-to-back fetches.
module tb_mem_arb;

   logic        clka = 1'b0;
   logic        rst  = 1'b1;
   always #5 clka = ~clka;

   // LAT=2 instance signals
   logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_ack, d_ack, mem_en, mem_we, stallF, stallM;

   // LAT=1 instance signals
   logic        if_req1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
   logic [31:0] if_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
   logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic        if_ack1, d_ack1, mem_en1, mem_we1, stallF1, stallM1;

   int checks   = 0;
   int failures = 0;

   function automatic logic [31:0] rd_val(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h8C01_0004;
      return {16'hA5A5, a[15:0]};
   endfunction

   // Memory model: read data presented LAT cycles after the issue cycle.
   logic [31:0] pa0 = '0, pa1 = '0, pb0 = '0;
   always @(posedge clka) begin
      pa0 <= mem_addr;
      pa1 <= pa0;
      pb0 <= mem_addr1;
   end
   assign mem_rdata  = rd_val(pa1);
   assign mem_rdata1 = rd_val(pb0);

   mem_arb #(.LAT(2), .MAXD(4)) u_dut (
      .clka(clka), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stallF(stallF), .stallM(stallM)
   );

   mem_arb #(.LAT(1), .MAXD(4)) u_dut1 (
      .clka(clka), .rst(rst),
      .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
      .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
      .d_rdata(d_rdata1), .d_ack(d_ack1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1), .stallF(stallF1), .stallM(stallM1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clka);
      #2;
   endtask

   initial begin
      logic [31:0] gnt [10];
      logic [31:0] exp_gnt [10];
      int          icyc [3];
      int          n, ni, na;

      // Reset state, with a data request present while rst is high
      step();
      step();
      d_req  = 1'b1;
      d_addr = 32'h40;
      #1;
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_stallM", stallM, 1);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_acks", {if_ack, d_ack}, 0);
      d_req = 1'b0;

      // Fetch alone to 0x100, issued in the first cycle with rst low
      step();
      rst     = 1'b0;
      if_req  = 1'b1;
      if_addr = 32'h100;
      #1;
      check("f_issue_en", mem_en, 1);
      check("f_issue_addr", mem_addr, 32'h100);
      check("f_issue_we", mem_we, 0);
      check("f_stallF_t", stallF, 1);
      step();
      check("f_t1_en", mem_en, 0);
      check("f_t1_stallF", stallF, 1);
      step();
      check("f_t2_ack", if_ack, 0);
      check("f_t2_stallF", stallF, 1);
      step();
      check("f_t3_ack", if_ack, 1);
      check("f_t3_rdata", if_rdata, 32'h8C01_0004);
      check("f_t3_stallF", stallF, 0);
      if_req = 1'b0;
      step();
      check("f_t4_ack", if_ack, 0);
      check("f_t4_hold", if_rdata, 32'h8C01_0004);

      // Data write to 0x40
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h40;
      d_wdata = 32'hDEAD_BEEF;
      #1;
      check("w_en", mem_en, 1);
      check("w_we", mem_we, 1);
      check("w_addr", mem_addr, 32'h40);
      check("w_wdata", mem_wdata, 32'hDEAD_BEEF);
      step();
      check("w_ack", d_ack, 1);
      check("w_rdata_unch", d_rdata, 0);
      check("w_stallM", stallM, 0);
      d_req = 1'b0;
      d_we  = 1'b0;
      step();
      check("w_ack_pulse", d_ack, 0);

      // Simultaneous data read and fetch: data first, fetch in data ack cycle
      d_req   = 1'b1;
      d_addr  = 32'h200;
      if_req  = 1'b1;
      if_addr = 32'h104;
      #1;
      check("s_first_addr", mem_addr, 32'h200);
      check("s_first_en", mem_en, 1);
      step();
      step();
      step();
      check("s_d_ack", d_ack, 1);
      check("s_d_rdata", d_rdata, 32'hA5A5_0200);
      check("s_if_ack_none", if_ack, 0);
      d_req = 1'b0;
      #1;
      check("s_fetch_en", mem_en, 1);
      check("s_fetch_addr", mem_addr, 32'h104);
      step();
      step();
      check("s_if_ack_early", if_ack, 0);
      step();
      check("s_if_ack", if_ack, 1);
      check("s_if_rdata", if_rdata, 32'hA5A5_0104);
      check("s_d_ack_off", d_ack, 0);
      if_req = 1'b0;
      step();

      // Starvation limit: both held, expect D D D D I D D D D I
      d_req   = 1'b1;
      d_addr  = 32'h200;
      if_req  = 1'b1;
      if_addr = 32'h300;
      exp_gnt = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h300,
                  32'h200, 32'h200, 32'h200, 32'h200, 32'h300};
      n = 0;
      #1;
      for (int c = 0; c < 40 && n < 10; c++) begin
         if (mem_en) begin
            gnt[n] = mem_addr;
            n++;
         end
         step();
      end
      check("mx_grant_count", 32'(n), 10);
      for (int i = 0; i < n; i++)
         check($sformatf("mx_grant%0d", i), gnt[i], exp_gnt[i]);
      d_req  = 1'b0;
      if_req = 1'b0;
      repeat (4) step();

      // Reset in cycle t+1 of a fetch: no ack, state cleared, then a clean fetch
      if_req  = 1'b1;
      if_addr = 32'h108;
      #1;
      check("r_issue_en", mem_en, 1);
      step();
      rst    = 1'b1;
      if_req = 1'b0;
      #1;
      check("r_en_in_rst", mem_en, 0);
      step();
      rst = 1'b0;
      check("r_if_rdata", if_rdata, 0);
      check("r_d_rdata", d_rdata, 0);
      check("r_outs", {if_ack, d_ack, mem_en, mem_we, stallF, stallM}, 0);
      check("r_mem_addr", mem_addr, 0);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("r_no_ack%0d", c), if_ack, 0);
         step();
      end
      if_req  = 1'b1;
      if_addr = 32'h10C;
      #1;
      check("r_new_en", mem_en, 1);
      step();
      step();
      step();
      check("r_new_ack", if_ack, 1);
      check("r_new_rdata", if_rdata, 32'hA5A5_010C);
      if_req = 1'b0;
      step();

      // LAT=1 back-to-back fetches 0x0, 0x4, 0x8
      if_req1  = 1'b1;
      if_addr1 = 32'h0;
      ni = 0;
      na = 0;
      #1;
      for (int c = 0; c < 12; c++) begin
         if (if_ack1) begin
            check($sformatf("b_rdata%0d", na), if_rdata1, 32'hA5A5_0000 + 32'(4 * na));
            na++;
            if (na == 3) if_req1 = 1'b0;
            else if_addr1 = if_addr1 + 32'd4;
         end
         #1;
         if (mem_en1) begin
            if (ni < 3) begin
               check($sformatf("b_addr%0d", ni), mem_addr1, 32'(4 * ni));
               icyc[ni] = c;
            end
            ni++;
         end
         step();
      end
      check("b_issue_count", 32'(ni), 3);
      check("b_ack_count", 32'(na), 3);
      if (ni >= 3) begin
         check("b_gap01", 32'(icyc[1] - icyc[0]), 2);
         check("b_gap12", 32'(icyc[2] - icyc[1]), 2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter LAT, default 2, meaning read latency in cycles from mem_en issue to valid mem_rdata; legal range 1..4.
REQ-002 The block SHALL have parameter MAXD, default 4, meaning the maximum number of consecutive data grants while a fetch is pending; legal range 1..7.
Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clka, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; synchronous, active-high.
REQ-005 The block SHALL have ports if_req (in, 1) and if_addr (in, 32) for the instruction-fetch request and word address.
REQ-006 The block SHALL have ports if_rdata (out, 32) and if_ack (out, 1) for the fetch read data and the one-cycle completion pulse.
REQ-007 The block SHALL have data-port inputs d_req (1, memen), d_we (1, memwrite), d_addr (32) and d_wdata (32).
REQ-008 The block SHALL have data-port outputs d_rdata (32) and d_ack (1).
REQ-009 The block SHALL have memory-side outputs mem_en (1), mem_we (1), mem_addr (32) and mem_wdata (32), and memory-side input mem_rdata (32).
REQ-010 The block SHALL have outputs stallF (1) and stallM (1), which are pipeline stall requests for the fetch and memory stages.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY_I and BUSY_D, and SHALL own exactly one access to the single-port memory at a time.
REQ-012 In IDLE with a request pending, the block SHALL issue in that cycle: mem_en=1 for exactly one cycle, with mem_addr, mem_we and mem_wdata taken from the granted port (mem_we=0 and mem_wdata=0 for a fetch); the FSM SHALL then go to BUSY_I or BUSY_D.
REQ-013 Arbitration SHALL give the data port priority over fetch, except that when dcnt==MAXD and if_req=1, fetch SHALL win.
REQ-014 dcnt (3-bit) SHALL increment on each data grant made while if_req=1, SHALL saturate at MAXD, and SHALL clear on any fetch grant or whenever if_req=0 in IDLE.
REQ-015 For a read issued in cycle t, the granted port's rdata register SHALL load mem_rdata at the end of cycle t+LAT, and ack SHALL pulse high in cycle t+LAT+1 with rdata valid.
REQ-016 For a write issued in cycle t, d_ack SHALL pulse in cycle t+1 and d_rdata SHALL be unchanged.
REQ-017 The latency counter SHALL be 3 bits, SHALL load LAT at issue, decrement each BUSY cycle, and trigger the ack at zero; it SHALL never wrap.
REQ-018 In the ack cycle the FSM SHALL be in IDLE and MAY issue a new access in that same cycle (back-to-back, one access per LAT+1 cycles for reads).
REQ-019 Requesters SHALL hold req, addr, we and wdata stable until ack; the block SHALL sample them only at issue.
REQ-020 A req still high in the ack cycle SHALL be treated as a new request.
REQ-021 The rdata registers SHALL hold their last value until next loaded.
REQ-022 stallF SHALL equal if_req & ~if_ack, and stallM SHALL equal d_req & ~d_ack (combinational).
REQ-023 if_ack and d_ack SHALL never both be high in the same cycle, and mem_en SHALL never be high outside an issue cycle.
REQ-024 If d_req and if_req rise in the same IDLE cycle with dcnt<MAXD, the data port SHALL be granted, and the fetch SHALL issue in the data ack cycle.

Reset
REQ-025 While rst=1 at a clock edge, the FSM SHALL go to IDLE, latency counter=0, dcnt=0, if_rdata=0, d_rdata=0, and if_ack=d_ack=0.
REQ-026 While rst=1 at a clock edge, mem_en, mem_we, mem_addr and mem_wdata SHALL be 0; stallF and stallM follow REQ-022.
REQ-027 Reset asserted mid-access SHALL discard the in-flight access, and no ack SHALL ever be produced for it.
REQ-028 The first issue after reset SHALL be possible in the first cycle with rst=0.

Verification
REQ-029 The bench SHALL cover: LAT=2, fetch alone to addr 0x100, mem returns 0x8C010004 -> mem_en in cycle t, if_ack in t+3, if_rdata=0x8C010004, stallF high t..t+2.
REQ-030 The bench SHALL cover: d_req/d_we=1 to 0x40, data 0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF in issue cycle, d_ack in t+1, d_rdata unchanged.
REQ-031 The bench SHALL cover: simultaneous if_req and d_req (read) -> data issues first, fetch issues in the data ack cycle, if_ack 2*(LAT+1) cycles after start.
REQ-032 The bench SHALL cover: MAXD=4, d_req held continuously with if_req held -> 4 data grants, then one fetch grant, then data resumes with dcnt=0.
REQ-033 The bench SHALL cover: rst pulsed in cycle t+1 of a LAT=2 read -> no ack ever, all outputs 0 the next cycle, a new fetch completes normally.
REQ-034 The bench SHALL cover: LAT=1, back-to-back fetches to 0x0, 0x4, 0x8 -> mem_en every 2 cycles, three if_ack pulses with matching data.
